// File: rtl/hd44780_xfer_engine.sv
// hd44780_xfer_engine: FIFO-fed HD44780 transfer engine for a 4-bit or 8-bit bus.
// Generates RS/data setup, E pulse width, E cycle time and the post-byte
// execution wait internally; upstream only pushes (rs, byte) entries.
// Optional feature macro: H4XE_NYBBLE_ONLY_EN adds i_nyb_only (high nybble only
// on a 4-bit bus, used for the 0x3/0x2 init nybbles).
module hd44780_xfer_engine #(
    parameter int unsigned BUS_WIDTH       = 4,
    parameter int unsigned FIFO_AW         = 2,
    parameter int unsigned TICKS_TAS       = 3,
    parameter int unsigned TICKS_PWEH      = 22,
    parameter int unsigned TICKS_TCYCE     = 48,
    parameter int unsigned TICKS_EXEC      = 2544,
    parameter int unsigned TICKS_EXEC_LONG = 76800,
    parameter int unsigned TIMER_BITS      = 17
) (
    input  logic                 CLK_I,
    input  logic                 RST_I,
    input  logic                 STB_I,
    input  logic                 i_rs,
    input  logic [7:0]           i_data,
`ifdef H4XE_NYBBLE_ONLY_EN
    input  logic                 i_nyb_only,
`endif
    output logic                 o_busy,
    output logic                 o_full,
    output logic                 o_ovf,
    output logic                 o_rs,
    output logic [BUS_WIDTH-1:0] o_lcd_data,
    output logic                 o_e
);

    localparam int unsigned       DEPTH   = 1 << FIFO_AW;
    localparam logic [FIFO_AW:0]  DEPTH_C = (FIFO_AW + 1)'(DEPTH);
    localparam logic [FIFO_AW:0]  CNT_ONE = (FIFO_AW + 1)'(1);
    localparam logic [FIFO_AW-1:0] PTR_ONE = FIFO_AW'(1);
    localparam bit                IS4     = (BUS_WIDTH == 4);

    // Timer reload values: a state lasting N clocks loads N-1 and leaves at zero.
    localparam logic [TIMER_BITS-1:0] LD_TAS       = TIMER_BITS'(TICKS_TAS - 1);
    localparam logic [TIMER_BITS-1:0] LD_PWEH      = TIMER_BITS'(TICKS_PWEH - 1);
    localparam logic [TIMER_BITS-1:0] LD_ELOW_LAST = TIMER_BITS'(TICKS_TCYCE - TICKS_PWEH - 1);
    localparam logic [TIMER_BITS-1:0] LD_ELOW_MID  = TIMER_BITS'(TICKS_TCYCE - TICKS_PWEH - TICKS_TAS - 1);
    localparam logic [TIMER_BITS-1:0] LD_EXEC      = TIMER_BITS'(TICKS_EXEC - 1);
    localparam logic [TIMER_BITS-1:0] LD_EXEC_LONG = TIMER_BITS'(TICKS_EXEC_LONG - 1);
    localparam logic [TIMER_BITS-1:0] TMR_ONE      = TIMER_BITS'(1);

    typedef struct packed {
        logic       nyb;
        logic       rs;
        logic [7:0] data;
    } entry_t;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        SETUP,
        EHIGH,
        ELOW,
        EXEC
    } state_t;

    entry_t                mem [DEPTH];
    logic [FIFO_AW-1:0]    wr_ptr;
    logic [FIFO_AW-1:0]    rd_ptr;
    logic [FIFO_AW:0]      count;
    entry_t                wr_entry;
    entry_t                shadow;
    logic                  push;
    logic                  pop;

    state_t                state;
    state_t                state_next;
    logic [TIMER_BITS-1:0] timer;
    logic [TIMER_BITS-1:0] timer_next;
    logic                  second_half;
    logic                  second_next;
    logic                  drive_first;
    logic                  drive_second;
    logic                  split;
    logic                  exec_long;
    logic [BUS_WIDTH-1:0]  first_bus;
    logic [BUS_WIDTH-1:0]  second_bus;

    assign o_full = (count == DEPTH_C);
    assign o_busy = (count != '0) || (state != IDLE);
    assign push   = STB_I && !o_full;

    // Entry presented for a push.
    always_comb begin
        wr_entry.rs   = i_rs;
        wr_entry.data = i_data;
`ifdef H4XE_NYBBLE_ONLY_EN
        wr_entry.nyb  = i_nyb_only;
`else
        wr_entry.nyb  = 1'b0;
`endif
    end

    // Two E cycles per byte only on a 4-bit bus for full-byte entries.
    assign split     = IS4 && !shadow.nyb;
    // Clear (0x01) and Home (0x02/0x03) need the long execution wait.
    assign exec_long = !shadow.rs && (shadow.data[7:2] == 6'd0) && (shadow.data != 8'd0);

    generate
        if (BUS_WIDTH == 8) begin : g_bus8
            assign first_bus  = shadow.data;
            assign second_bus = shadow.data;
        end else begin : g_bus4
            assign first_bus  = shadow.data[7:4];
            assign second_bus = shadow.data[3:0];
        end
    endgenerate

    // FIFO storage, pointers, occupancy and sticky overflow flag.
    always_ff @(posedge CLK_I) begin
        if (RST_I) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            o_ovf  <= 1'b0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= wr_entry;
                wr_ptr      <= wr_ptr + PTR_ONE;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_ONE;
            end
            if (STB_I && o_full) begin
                o_ovf <= 1'b1;
            end
            case ({push, pop})
                2'b10:   count <= count + CNT_ONE;
                2'b01:   count <= count - CNT_ONE;
                default: count <= count;
            endcase
        end
    end

    // Next-state, timer reload and bus-drive strobes for the transfer FSM.
    // ELOW is shortened by TAS when another nybble follows, so the next E rise
    // lands exactly TCYCE after the previous one.
    always_comb begin
        state_next   = state;
        timer_next   = timer;
        second_next  = second_half;
        pop          = 1'b0;
        drive_first  = 1'b0;
        drive_second = 1'b0;
        unique case (state)
            IDLE: begin
                if (count != '0) begin
                    pop        = 1'b1;
                    state_next = LOAD;
                end
            end
            LOAD: begin
                drive_first = 1'b1;
                second_next = 1'b0;
                timer_next  = LD_TAS;
                state_next  = SETUP;
            end
            SETUP: begin
                if (timer == '0) begin
                    timer_next = LD_PWEH;
                    state_next = EHIGH;
                end else begin
                    timer_next = timer - TMR_ONE;
                end
            end
            EHIGH: begin
                if (timer == '0) begin
                    timer_next = (split && !second_half) ? LD_ELOW_MID : LD_ELOW_LAST;
                    state_next = ELOW;
                end else begin
                    timer_next = timer - TMR_ONE;
                end
            end
            ELOW: begin
                if (timer == '0) begin
                    if (split && !second_half) begin
                        drive_second = 1'b1;
                        second_next  = 1'b1;
                        timer_next   = LD_TAS;
                        state_next   = SETUP;
                    end else begin
                        timer_next = exec_long ? LD_EXEC_LONG : LD_EXEC;
                        state_next = EXEC;
                    end
                end else begin
                    timer_next = timer - TMR_ONE;
                end
            end
            EXEC: begin
                if (timer == '0) begin
                    state_next = IDLE;
                end else begin
                    timer_next = timer - TMR_ONE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // FSM state, timer and nybble-phase registers.
    always_ff @(posedge CLK_I) begin
        if (RST_I) begin
            state       <= IDLE;
            timer       <= '0;
            second_half <= 1'b0;
        end else begin
            state       <= state_next;
            timer       <= timer_next;
            second_half <= second_next;
        end
    end

    // Shadow entry and registered LCD pins; E is high exactly while in EHIGH.
    always_ff @(posedge CLK_I) begin
        if (RST_I) begin
            shadow     <= '0;
            o_rs       <= 1'b0;
            o_lcd_data <= '0;
            o_e        <= 1'b0;
        end else begin
            o_e <= (state_next == EHIGH);
            if (pop) begin
                shadow <= mem[rd_ptr];
            end
            if (drive_first) begin
                o_rs       <= shadow.rs;
                o_lcd_data <= first_bus;
            end
            if (drive_second) begin
                o_lcd_data <= second_bus;
            end
        end
    end

endmodule

// File: tb/tb_hd44780_xfer_engine.sv
// Self-checking bench for hd44780_xfer_engine: one 4-bit and one 8-bit instance,
// directed scenarios plus randomized rounds checked against a transaction-level
// model of the expected LCD bus activity.
module tb_hd44780_xfer_engine;

    localparam int TAS       = 2;
    localparam int PWEH      = 4;
    localparam int TCYCE     = 10;
    localparam int EXEC      = 20;
    localparam int EXEC_LONG = 50;

    typedef struct {
        bit         nyb;
        bit         rs;
        logic [7:0] data;
    } ent_t;

    typedef struct {
        int         rise;
        int         fall;
        bit         rs;
        logic [7:0] data;
        bit         stable;
        int         setup;
    } pulse_t;

    logic       clk = 1'b0;
    logic       rst;
    logic       stb4;
    logic       stb8;
    logic       rs_in;
    logic [7:0] data_in;
`ifdef H4XE_NYBBLE_ONLY_EN
    logic       nyb_in;
`endif

    logic       busy4, full4, ovf4, rs4, e4;
    logic [3:0] lcd4;
    logic       busy8, full8, ovf8, rs8, e8;
    logic [7:0] lcd8;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    ent_t   expq4[$];
    ent_t   expq8[$];
    pulse_t pq4[$];
    pulse_t pq8[$];

    logic       mon_e[2];
    logic       mon_rs[2];
    logic       mon_busy[2];
    logic [7:0] mon_d[2];
    bit         prev_e[2];
    bit         prev_busy[2];
    logic [8:0] prev_bus[2];
    int         last_chg[2];
    int         busy_fall[2];
    pulse_t     cur[2];

    always #5 clk = ~clk;

    hd44780_xfer_engine #(
        .BUS_WIDTH(4), .FIFO_AW(2), .TICKS_TAS(TAS), .TICKS_PWEH(PWEH),
        .TICKS_TCYCE(TCYCE), .TICKS_EXEC(EXEC), .TICKS_EXEC_LONG(EXEC_LONG), .TIMER_BITS(17)
    ) dut4 (
        .CLK_I(clk), .RST_I(rst), .STB_I(stb4), .i_rs(rs_in), .i_data(data_in),
`ifdef H4XE_NYBBLE_ONLY_EN
        .i_nyb_only(nyb_in),
`endif
        .o_busy(busy4), .o_full(full4), .o_ovf(ovf4), .o_rs(rs4),
        .o_lcd_data(lcd4), .o_e(e4)
    );

    hd44780_xfer_engine #(
        .BUS_WIDTH(8), .FIFO_AW(2), .TICKS_TAS(TAS), .TICKS_PWEH(PWEH),
        .TICKS_TCYCE(TCYCE), .TICKS_EXEC(EXEC), .TICKS_EXEC_LONG(EXEC_LONG), .TIMER_BITS(17)
    ) dut8 (
        .CLK_I(clk), .RST_I(rst), .STB_I(stb8), .i_rs(rs_in), .i_data(data_in),
`ifdef H4XE_NYBBLE_ONLY_EN
        .i_nyb_only(nyb_in),
`endif
        .o_busy(busy8), .o_full(full8), .o_ovf(ovf8), .o_rs(rs8),
        .o_lcd_data(lcd8), .o_e(e8)
    );

    assign mon_e[0]    = e4;
    assign mon_e[1]    = e8;
    assign mon_rs[0]   = rs4;
    assign mon_rs[1]   = rs8;
    assign mon_busy[0] = busy4;
    assign mon_busy[1] = busy8;
    assign mon_d[0]    = {4'h0, lcd4};
    assign mon_d[1]    = lcd8;

    // Edge counter; a value seen at a falling edge names the preceding rising edge.
    always @(posedge clk) cyc <= cyc + 1;

    // Bus monitor: records each E pulse with its timing, strobed value and stability.
    initial begin
        forever begin
            @(negedge clk);
            for (int d = 0; d < 2; d++) begin
                if ({mon_rs[d], mon_d[d]} !== prev_bus[d]) last_chg[d] = cyc;
                if (mon_e[d] && !prev_e[d]) begin
                    cur[d].rise   = cyc;
                    cur[d].rs     = mon_rs[d];
                    cur[d].data   = mon_d[d];
                    cur[d].stable = 1'b1;
                    cur[d].setup  = cyc - last_chg[d];
                end else if (mon_e[d] && prev_e[d]) begin
                    if ({mon_rs[d], mon_d[d]} !== {cur[d].rs, cur[d].data}) cur[d].stable = 1'b0;
                end else if (!mon_e[d] && prev_e[d]) begin
                    cur[d].fall = cyc;
                    if (d == 0) pq4.push_back(cur[d]);
                    else        pq8.push_back(cur[d]);
                end
                if (prev_busy[d] && !mon_busy[d]) busy_fall[d] = cyc;
                prev_e[d]    = mon_e[d];
                prev_busy[d] = mon_busy[d];
                prev_bus[d]  = {mon_rs[d], mon_d[d]};
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, observed time limit, required completion");
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_tests++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    function automatic int exec_of(input ent_t e);
        return (!e.rs && (e.data == 8'h01 || e.data == 8'h02 || e.data == 8'h03)) ? EXEC_LONG : EXEC;
    endfunction

    function automatic int phases_of(input int d, input ent_t e);
        return (d == 0 && !e.nyb) ? 2 : 1;
    endfunction

    task automatic push(input int d, input bit nyb, input bit rs, input logic [7:0] data);
        ent_t e;
        rs_in   = rs;
        data_in = data;
`ifdef H4XE_NYBBLE_ONLY_EN
        nyb_in  = nyb;
        e.nyb   = nyb;
`else
        e.nyb   = 1'b0;
`endif
        e.rs   = rs;
        e.data = data;
        if (d == 0) begin stb4 = 1'b1; expq4.push_back(e); end
        else        begin stb8 = 1'b1; expq8.push_back(e); end
        @(negedge clk);
        stb4 = 1'b0;
        stb8 = 1'b0;
    endtask

    task automatic wait_idle(input int d);
        logic b;
        for (int i = 0; i < 3000; i++) begin
            b = (d == 0) ? busy4 : busy8;
            if (!b) break;
            @(negedge clk);
        end
        b = (d == 0) ? busy4 : busy8;
        chk("idle_timeout", b, 1'b0);
        @(negedge clk);
    endtask

    // Compare every recorded pulse of one instance with the expected entry stream.
    task automatic check_round(input int d);
        ent_t       e;
        pulse_t     p;
        int         n_exp;
        int         got;
        int         nph;
        int         prev_rise;
        int         prev_exec;
        bit         first;
        logic [7:0] want;
        wait_idle(d);
        n_exp = 0;
        if (d == 0) foreach (expq4[i]) n_exp += phases_of(0, expq4[i]);
        else        foreach (expq8[i]) n_exp += phases_of(1, expq8[i]);
        got = (d == 0) ? pq4.size() : pq8.size();
        chk("pulse_count", got, n_exp);
        first     = 1'b1;
        prev_rise = 0;
        prev_exec = 0;
        while ((d == 0) ? (expq4.size() > 0) : (expq8.size() > 0)) begin
            e   = (d == 0) ? expq4.pop_front() : expq8.pop_front();
            nph = phases_of(d, e);
            for (int k = 0; k < nph; k++) begin
                if ((d == 0) ? (pq4.size() == 0) : (pq8.size() == 0)) break;
                p = (d == 0) ? pq4.pop_front() : pq8.pop_front();
                if (d == 1)      want = e.data;
                else if (k == 0) want = {4'h0, e.data[7:4]};
                else             want = {4'h0, e.data[3:0]};
                chk("rs", p.rs, e.rs);
                chk("data", p.data, want);
                chk("e_width", p.fall - p.rise, PWEH);
                chk("stable_while_e", p.stable, 1'b1);
                chk("setup_ge_tas", p.setup >= TAS, 1'b1);
                if (k == 1)
                    chk("nybble_spacing", p.rise - prev_rise, TCYCE);
                else if (!first)
                    chk("byte_spacing", p.rise - prev_rise, TCYCE + prev_exec + 2 + TAS);
                prev_rise = p.rise;
                first     = 1'b0;
            end
            prev_exec = exec_of(e);
        end
        chk("busy_fall", busy_fall[d], prev_rise + TCYCE + prev_exec);
        if (d == 0) pq4.delete();
        else        pq8.delete();
    endtask

    initial begin
        int         n;
        bit         rrs;
        bit         rnyb;
        logic [7:0] rdat;
        ent_t       e;

        rst = 1'b1; stb4 = 1'b0; stb8 = 1'b0; rs_in = 1'b0; data_in = 8'h00;
`ifdef H4XE_NYBBLE_ONLY_EN
        nyb_in = 1'b0;
`endif
        repeat (3) @(negedge clk);
        // Reset state of both instances.
        chk("rst_e4", e4, 1'b0);
        chk("rst_busy4", busy4, 1'b0);
        chk("rst_full4", full4, 1'b0);
        chk("rst_ovf4", ovf4, 1'b0);
        chk("rst_rs4", rs4, 1'b0);
        chk("rst_lcd4", lcd4, 4'h0);
        chk("rst_e8", e8, 1'b0);
        chk("rst_busy8", busy8, 1'b0);
        chk("rst_lcd8", lcd8, 8'h00);
        rst = 1'b0;
        @(negedge clk);

        // Single data byte on the 4-bit bus.
        push(0, 1'b0, 1'b1, 8'hA5);
        check_round(0);

        // Long wait only for rs=0 Clear/Home.
        push(0, 1'b0, 1'b0, 8'h01);
        push(0, 1'b0, 1'b1, 8'h01);
        push(0, 1'b0, 1'b0, 8'h03);
        push(0, 1'b0, 1'b0, 8'h04);
        check_round(0);

        // Overflow: hold STB for 5 clocks while a transfer is in flight.
        push(0, 1'b0, 1'b1, 8'h20);
        for (int i = 0; i < 100; i++) begin
            if (e4) break;
            @(negedge clk);
        end
        chk("e_rise_seen", e4, 1'b1);
        chk("ovf_before", ovf4, 1'b0);
        rs_in = 1'b1;
        for (int k = 0; k < 5; k++) begin
            rdat    = 8'h11 + 8'(k);
            data_in = rdat;
            stb4    = 1'b1;
            @(negedge clk);
            chk("full_after_push", full4, k >= 3);
            chk("ovf_after_push", ovf4, k >= 4);
            if (k < 4) begin
                e.nyb = 1'b0; e.rs = 1'b1; e.data = rdat;
                expq4.push_back(e);
            end
        end
        stb4 = 1'b0;
        check_round(0);
        chk("ovf_sticky", ovf4, 1'b1);

        // Reset in the middle of an E-high phase with entries queued.
        push(0, 1'b0, 1'b1, 8'h61);
        push(0, 1'b0, 1'b1, 8'h62);
        push(0, 1'b0, 1'b1, 8'h63);
        for (int i = 0; i < 100; i++) begin
            if (e4) break;
            @(negedge clk);
        end
        chk("e_high_before_rst", e4, 1'b1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("midrst_e", e4, 1'b0);
        chk("midrst_busy", busy4, 1'b0);
        chk("midrst_full", full4, 1'b0);
        chk("midrst_ovf", ovf4, 1'b0);
        chk("midrst_lcd", lcd4, 4'h0);
        @(negedge clk);
        pq4.delete();
        expq4.delete();
        push(0, 1'b0, 1'b1, 8'h41);
        check_round(0);

        // 8-bit bus: one E cycle per byte.
        push(1, 1'b0, 1'b0, 8'h38);
        check_round(1);

`ifdef H4XE_NYBBLE_ONLY_EN
        // High nybble only on 4-bit; ignored on 8-bit.
        push(0, 1'b1, 1'b0, 8'h30);
        check_round(0);
        push(1, 1'b1, 1'b0, 8'h30);
        check_round(1);
`endif

        // Randomized bursts on both instances.
        for (int r = 0; r < 10; r++) begin
            n = $urandom_range(1, 4);
            for (int k = 0; k < n; k++) begin
                rrs  = 1'($urandom_range(0, 1));
                rnyb = ($urandom_range(0, 3) == 0);
                if ($urandom_range(0, 2) == 0) rdat = 8'($urandom_range(0, 4));
                else                           rdat = 8'($urandom);
                push((r % 3 == 2) ? 1 : 0, rnyb, rrs, rdat);
            end
            check_round((r % 3 == 2) ? 1 : 0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
